debounce_bank: RTL
==================

// Module: debounce_bank
//
// PURPOSE
//   Parametrised N-channel button/switch debouncer for the game controller inputs
//   (paddle up/down, serve, pause, ...). Each raw pin is synchronised, filtered by a
//   per-channel stability counter, and presented as a clean level. The block also
//   produces one-cycle press/release pulses and an optional hold-to-auto-repeat pulse
//   for paddle movement. It sits between the board pins and the game FSM / paddle logic.
//
// PARAMETERS
//   N_CH          5          number of independent input channels
//   CNT_W         20         width of each stability counter
//   DEB_CYCLES    1_000_000  consecutive mismatching cycles required to accept a change (>=2, < 2**CNT_W)
//   RST_VAL       0          reset value (N_CH bits) of sync flops and debounced levels
//   REPEAT_EN     1          1 = auto-repeat generated on held channels; 0 = disabled
//   HOLD_W        26         width of each hold counter
//   REPEAT_DELAY  25_000_000 cycles from press pulse to first repeat pulse (>=1)
//   REPEAT_RATE   5_000_000  cycles between subsequent repeat pulses (>=1)
//
// PORTS
//   clk        in   1     single system clock; all logic on rising edge
//   rst_n      in   1     asynchronous, active-low reset
//   raw_in     in   N_CH  raw asynchronous pin levels
//   level      out  N_CH  debounced stable level per channel
//   rise       out  N_CH  1-cycle pulse when level goes 0->1 (press)
//   fall       out  N_CH  1-cycle pulse when level goes 1->0 (release)
//   press_rpt  out  N_CH  rise OR auto-repeat pulse (1 cycle each)
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync flops and level = RST_VAL; counters = 0;
//     rise, fall, press_rpt = 0. Release is taken synchronously via normal clocking.
//   - Sync: 2-flop synchroniser per channel; s[i] = second flop. 2-cycle latency.
//   - Filter, per channel, each edge:
//       s[i]==level[i]                  -> cnt<=0
//       s[i]!=level[i], cnt<DEB_CYCLES-1 -> cnt<=cnt+1
//       s[i]!=level[i], cnt==DEB_CYCLES-1 -> level<=s[i], cnt<=0, rise/fall pulse
//     i.e. level updates on the DEB_CYCLES-th consecutive edge with mismatch; any
//     single matching sample restarts the count. Pin-to-level latency = 2+DEB_CYCLES.
//   - rise/fall asserted in the same cycle level changes is visible; exactly 1 cycle.
//   - Auto-repeat (REPEAT_EN=1), per channel, hold counter hcnt + flag first:
//       on rise edge: hcnt<=0, first<=1
//       while level=1: hcnt++ ; when hcnt reaches REPEAT_DELAY-1 (first=1) or
//       REPEAT_RATE-1 (first=0): repeat pulse, hcnt<=0, first<=0
//       level=0: hcnt<=0, no pulses; release cancels any pending repeat.
//     First repeat pulse occurs REPEAT_DELAY cycles after the rise pulse, then every
//     REPEAT_RATE cycles. press_rpt = rise | repeat. REPEAT_EN=0: press_rpt == rise.
//   - Channels fully independent; simultaneous changes on several channels each
//     produce their own pulses in the same cycle.
//   - Counters never wrap: filter counter bounded by DEB_CYCLES-1, hold counter by
//     max(REPEAT_DELAY,REPEAT_RATE)-1.
//   - Reset mid-count or mid-hold: all state discarded, outputs return to reset values
//     immediately; no pulse emitted on reset assertion or release.
//
// TESTING (bench params: N_CH=5, DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
//   1. raw_in[0] 0->1, held -> level[0]=1 exactly 6 edges later; rise[0] one cycle;
//      fall, other channels quiet.
//   2. raw_in[1] high 3 cycles, low 1, high 3 (bounce) -> level[1] stays 0, no pulses.
//   3. raw_in[2] held high 30 cycles -> rise at T, press_rpt at T, T+10, T+13, T+16...;
//      release -> fall after 6 edges, no further repeats.
//   4. All 5 channels 0->1 same cycle -> rise=5'b11111 in a single cycle.
//   5. rst_n asserted while cnt=2 and while level[3]=1 held -> level=RST_VAL, counters
//      cleared, no pulses; after release needs full 6 edges again.
//   6. REPEAT_EN=0, channel held 50 cycles -> press_rpt only at rise, equals rise.

Source files
------------

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//   N-channel debouncer for the game controller pins. Each raw pin goes through
//   a 2-flop synchroniser. A per-channel stability counter then filters it into
//   a clean level. The block also emits one-cycle press/release pulses and an
//   optional hold-to-auto-repeat pulse for paddle movement.
//
// Ports
//   clk        in   1     system clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   raw_in     in   N_CH  raw asynchronous pin levels
//   level      out  N_CH  debounced level per channel
//   rise       out  N_CH  1-cycle pulse on level 0->1
//   fall       out  N_CH  1-cycle pulse on level 1->0
//   press_rpt  out  N_CH  rise OR auto-repeat pulse
// -----------------------------------------------------------------------------
module debounce_bank #(
  parameter int              N_CH         = 5,
  parameter int              CNT_W        = 20,
  parameter int              DEB_CYCLES   = 1_000_000,
  parameter logic [N_CH-1:0] RST_VAL      = '0,
  parameter bit              REPEAT_EN    = 1'b1,
  parameter int              HOLD_W       = 26,
  parameter int              REPEAT_DELAY = 25_000_000,
  parameter int              REPEAT_RATE  = 5_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press_rpt
);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST = HOLD_W'(REPEAT_RATE - 1);

  logic [N_CH-1:0]             sync1_q, sync1_d;
  logic [N_CH-1:0]             sync2_q, sync2_d;
  logic [N_CH-1:0]             level_q, level_d;
  logic [N_CH-1:0]             rise_q, rise_d;
  logic [N_CH-1:0]             fall_q, fall_d;
  logic [N_CH-1:0]             rpt_q, rpt_d;
  logic [N_CH-1:0]             first_q, first_d;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0][HOLD_W-1:0] hcnt_q, hcnt_d;

  // Synchroniser and stability filter. Any sample that matches the current
  // level restarts the count, so only an unbroken run of DEB_CYCLES
  // mismatching samples is accepted as a change.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Auto-repeat. This logic looks at the next level so that a release edge
  // cancels any repeat due in the same cycle. It also restarts the hold timer
  // together with the rise pulse. 'first' selects the long initial delay
  // versus the shorter repeat interval.
  always_comb begin
    hcnt_d  = hcnt_q;
    first_d = first_q;
    rpt_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!REPEAT_EN || !level_d[i]) begin
        hcnt_d[i] = '0;
      end else if (rise_d[i]) begin
        hcnt_d[i]  = '0;
        first_d[i] = 1'b1;
      end else if (hcnt_q[i] == (first_q[i] ? DLY_LAST : RATE_LAST)) begin
        rpt_d[i]   = 1'b1;
        hcnt_d[i]  = '0;
        first_d[i] = 1'b0;
      end else begin
        hcnt_d[i] = hcnt_q[i] + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      level_q <= RST_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      rpt_q   <= '0;
      first_q <= '0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign press_rpt = rise_q | rpt_q;

endmodule
